// File: rtl/operand_fetch_if.sv
// ----------------------------------------------------------------------------
// operand_fetch_if
// Bundles every non-clock signal of the operand fetch stage: the decode-side
// request handshake, the register-file read port, the constant-table port and
// the execute-side operand handshake.
//
// Signals (direction as seen by the fetch stage, modport slave):
//   flush        in   1     synchronous abort of any fetch in progress
//   req_valid    in   1     decode presents an instruction
//   req_ready    out  1     stage can accept (high only in IDLE)
//   rc           in   1     1 = src is a constant-table index, 0 = register
//   src          in   3     source register number or constant index
//   dst          in   3     destination register number
//   rf_en        out  1     register-file read strobe
//   rf_addr      out  3     register-file read address
//   rf_data      in   WORD  register-file read data, one cycle after rf_en
//   const_addr   out  3     constant-table index (combinational ROM)
//   const_data   in   WORD  constant-table data, same cycle as const_addr
//   op_valid     out  1     operands valid for execute
//   op_ready     in   1     execute consumes operands
//   src_op       out  WORD  source operand (registered)
//   dst_op       out  WORD  destination operand (registered)
//
// modport slave  : the fetch stage itself
// modport master : the surrounding pipeline (decode, register file, ROM, execute)
// ----------------------------------------------------------------------------
interface operand_fetch_if #(
    parameter int WORD = 16
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic            rc;
    logic [2:0]      src;
    logic [2:0]      dst;
    logic            rf_en;
    logic [2:0]      rf_addr;
    logic [WORD-1:0] rf_data;
    logic [2:0]      const_addr;
    logic [WORD-1:0] const_data;
    logic            op_valid;
    logic            op_ready;
    logic [WORD-1:0] src_op;
    logic [WORD-1:0] dst_op;

    modport slave (
        input  flush, req_valid, rc, src, dst, rf_data, const_data, op_ready,
        output req_ready, rf_en, rf_addr, const_addr, op_valid, src_op, dst_op
    );

    modport master (
        output flush, req_valid, rc, src, dst, rf_data, const_data, op_ready,
        input  req_ready, rf_en, rf_addr, const_addr, op_valid, src_op, dst_op
    );
endinterface

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
// Multi-cycle operand fetch stage between decode and execute. An accepted
// instruction's dst register is read from the register file, then its source
// operand is taken either from the constant table (rc=1) or from a second
// register-file read (rc=0). Both operands are then held for execute behind a
// valid/ready handshake.
//
// Ports:
//   clk   in   1   clock, all state updates on the rising edge
//   rst   in   1   asynchronous, active-high reset
//   bus   slave modport of operand_fetch_if (request, register file,
//                 constant table and operand handshakes)
//
// Sequence: IDLE -> FETCH_D -> FETCH_S -> [WAIT_S ->] VALID -> IDLE
//   Counting the request cycle as cycle 0, op_valid rises in cycle 3 for a
//   constant source and in cycle 4 for a register source.
// ----------------------------------------------------------------------------
module operand_fetch #(
    parameter int WORD = 16
) (
    input  logic             clk,
    input  logic             rst,
    operand_fetch_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_D = 3'd1,
        FETCH_S = 3'd2,
        WAIT_S  = 3'd3,
        VALID   = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            rc_q;
    logic [2:0]      src_q;
    logic [2:0]      dst_q;
    logic [WORD-1:0] src_op_q;
    logic [WORD-1:0] dst_op_q;
    logic            accept;

    // Flush beats a simultaneous request, so a flushed IDLE cycle never latches.
    assign accept = (state_q == IDLE) && bus.req_valid && !bus.flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so that no path leaves it
    // unassigned; a missing assignment in always_comb would infer a latch.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.req_valid) state_d = FETCH_D;
                FETCH_D: state_d = FETCH_S;
                FETCH_S: state_d = rc_q ? VALID : WAIT_S;
                WAIT_S:  state_d = VALID;
                VALID:   if (bus.op_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Instruction field latches, loaded only on accept
    // ------------------------------------------------------------------
    // NOTE: every register here is reset explicitly; the design holds no
    // memory arrays, so the whole datapath starts from a known value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_q  <= 1'b0;
            src_q <= 3'd0;
            dst_q <= 3'd0;
        end else if (accept) begin
            rc_q  <= bus.rc;
            src_q <= bus.src;
            dst_q <= bus.dst;
        end
    end

    // ------------------------------------------------------------------
    // Operand capture. A flush suppresses the capture so the operand
    // registers keep whatever they held before the aborted fetch.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_op_q <= '0;
            dst_op_q <= '0;
        end else if (!bus.flush) begin
            case (state_q)
                FETCH_S: begin
                    // rf_data here answers the dst read issued in FETCH_D.
                    dst_op_q <= bus.rf_data;
                    if (rc_q) begin
                        src_op_q <= bus.const_data;
                    end
                end
                WAIT_S: begin
                    // rf_data here answers the src read issued in FETCH_S.
                    src_op_q <= bus.rf_data;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore outputs and read-port addressing
    // ------------------------------------------------------------------
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.op_valid   = (state_q == VALID);
    assign bus.rf_en      = (state_q == FETCH_D) || ((state_q == FETCH_S) && !rc_q);
    assign bus.rf_addr    = (state_q == FETCH_S) ? src_q : dst_q;
    assign bus.const_addr = src_q;
    assign bus.src_op     = src_op_q;
    assign bus.dst_op     = dst_op_q;

endmodule

// File: tb/tb_operand_fetch.sv
// ----------------------------------------------------------------------------
// tb_operand_fetch
// Directed bench for operand_fetch. A transaction-level model predicts, from
// the request stream alone, when the stage is busy, when operands become
// valid (request cycle + 3 for constants, + 4 for registers) and what they
// must contain; a compare process checks the DUT against it every cycle.
// Directed sequences add literal expectations for latency and operand values.
// ----------------------------------------------------------------------------
module tb_operand_fetch;

    localparam int WORD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    operand_fetch_if #(.WORD(WORD)) bus ();

    operand_fetch #(.WORD(WORD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ------------------------------------------------------------------
    // Environment: register file (one-cycle read) and constant ROM
    // ------------------------------------------------------------------
    logic [WORD-1:0] rf  [8];
    logic [WORD-1:0] rom [8];

    always @(posedge clk) begin
        if (bus.rf_en) bus.rf_data <= rf[bus.rf_addr];
    end

    assign bus.const_data = rom[bus.const_addr];

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a request is taken whenever the stage is not
    // busy and no flush is present; operands appear after a fixed latency and
    // stay until the execute handshake. Flush cancels any transaction.
    // ------------------------------------------------------------------
    bit              m_busy;
    bit              m_valid;
    int              m_left;
    logic [WORD-1:0] m_src;
    logic [WORD-1:0] m_dst;
    logic [2:0]      m_cidx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
            m_src   = '0;
            m_dst   = '0;
            m_cidx  = '0;
        end else if (bus.flush) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_left  = 0;
        end else if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy = 1'b1;
                m_left = bus.rc ? 2 : 3;
                m_src  = bus.rc ? rom[bus.src] : rf[bus.src];
                m_dst  = rf[bus.dst];
                m_cidx = bus.src;
            end
        end else if (m_valid) begin
            if (bus.op_ready) begin
                m_busy  = 1'b0;
                m_valid = 1'b0;
            end
        end else begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end
    end

    // Compare process: outputs are all registered or state-decoded, so the
    // falling edge is a stable sampling point.
    always @(negedge clk) begin
        if (!rst) begin
            check("op_valid", 32'(bus.op_valid), 32'(m_valid));
            check("req_ready", 32'(bus.req_ready), 32'(!m_busy));
            check("const_addr", 32'(bus.const_addr), 32'(m_cidx));
            if (m_valid) begin
                check("src_op", 32'(bus.src_op), 32'(m_src));
                check("dst_op", 32'(bus.dst_op), 32'(m_dst));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    // Present one request for exactly one cycle; returns at the next falling
    // edge (cycle 1 counted from the request cycle).
    task automatic present(input logic rc_v, input logic [2:0] s, input logic [2:0] d);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.rc        = rc_v;
        bus.src       = s;
        bus.dst       = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Advance falling edges until op_valid, starting from cycle n; bounded.
    task automatic wait_valid(inout int n);
        while (!bus.op_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic handshake();
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input logic rc_v, input logic [2:0] s,
                          input logic [2:0] d, input logic [WORD-1:0] exp_src,
                          input logic [WORD-1:0] exp_dst);
        int n;
        present(rc_v, s, d);
        n = 1;
        wait_valid(n);
        check({tag, " latency"}, 32'(n), rc_v ? 32'd3 : 32'd4);
        check({tag, " src_op"}, 32'(bus.src_op), 32'(exp_src));
        check({tag, " dst_op"}, 32'(bus.dst_op), 32'(exp_dst));
        handshake();
    endtask

    // Hand-computed constant values expected for indices 0..7.
    logic [WORD-1:0] rom_exp [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rc        = 1'b0;
        bus.src       = 3'd0;
        bus.dst       = 3'd0;
        bus.op_ready  = 1'b0;
        bus.rf_data   = '0;

        rf[0] = 16'h0001; rf[1] = 16'h1234; rf[2] = 16'h00FF; rf[3] = 16'hBEEF;
        rf[4] = 16'h0F0F; rf[5] = 16'hA5A5; rf[6] = 16'h8000; rf[7] = 16'h7FFF;
        rom[0] = 16'd0;  rom[1] = 16'd1;  rom[2] = 16'd2;  rom[3] = 16'd4;
        rom[4] = 16'd8;  rom[5] = 16'd16; rom[6] = 16'd32; rom[7] = 16'hFFFF;
        rom_exp[0] = 16'h0000; rom_exp[1] = 16'h0001; rom_exp[2] = 16'h0002; rom_exp[3] = 16'h0004;
        rom_exp[4] = 16'h0008; rom_exp[5] = 16'h0010; rom_exp[6] = 16'h0020; rom_exp[7] = 16'hFFFF;

        // Power-on reset
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("por op_valid", 32'(bus.op_valid), 32'd0);
        check("por req_ready", 32'(bus.req_ready), 32'd1);
        check("por src_op", 32'(bus.src_op), 32'd0);
        check("por dst_op", 32'(bus.dst_op), 32'd0);
        check("por rf_en", 32'(bus.rf_en), 32'd0);

        // Register source: R1 -> src, R2 -> dst
        do_txn("reg", 1'b0, 3'd1, 3'd2, 16'h1234, 16'h00FF);

        // Same register as both source and destination
        do_txn("same", 1'b0, 3'd5, 3'd5, 16'hA5A5, 16'hA5A5);

        // Every constant-table index
        for (int i = 0; i < 8; i++) begin
            do_txn($sformatf("const%0d", i), 1'b1, 3'(i), 3'd3, rom_exp[i], 16'hBEEF);
        end

        // Backpressure with a competing request that must not be latched
        present(1'b0, 3'd3, 3'd4);
        n = 1;
        wait_valid(n);
        check("bp latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            bus.req_valid = 1'b1;
            bus.rc        = 1'b1;
            bus.src       = 3'd7;
            bus.dst       = 3'd7;
            check("bp op_valid", 32'(bus.op_valid), 32'd1);
            check("bp req_ready", 32'(bus.req_ready), 32'd0);
            check("bp src_op", 32'(bus.src_op), 32'hBEEF);
            check("bp dst_op", 32'(bus.dst_op), 32'h0F0F);
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        handshake();
        check("bp not latched", 32'(bus.const_addr), 32'd3);
        check("bp idle", 32'(bus.op_valid), 32'd0);

        // Flush while waiting for the source read
        present(1'b0, 3'd1, 3'd6);
        @(negedge clk);                  // cycle 2: FETCH_S
        @(negedge clk);                  // cycle 3: WAIT_S
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush idle", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("flush no valid", 32'(bus.op_valid), 32'd0);
            @(negedge clk);
        end
        do_txn("post flush", 1'b0, 3'd6, 3'd1, 16'h8000, 16'h1234);

        // Flush together with a request in IDLE: no accept
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.rc        = 1'b1;
        bus.src       = 3'd5;
        bus.flush     = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("flush+req ready", 32'(bus.req_ready), 32'd1);
            check("flush+req no valid", 32'(bus.op_valid), 32'd0);
            @(negedge clk);
        end

        // Flush together with op_ready in VALID
        present(1'b1, 3'd4, 3'd0);
        n = 1;
        wait_valid(n);
        check("flush+rdy latency", 32'(n), 32'd3);
        bus.flush    = 1'b1;
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.op_ready = 1'b0;
        check("flush+rdy op_valid", 32'(bus.op_valid), 32'd0);
        check("flush+rdy req_ready", 32'(bus.req_ready), 32'd1);

        // Back-to-back with req_valid held high
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.rc        = 1'b1;
        bus.src       = 3'd2;
        bus.dst       = 3'd1;
        n = 0;
        wait_valid(n);
        check("b2b first latency", 32'(n), 32'd3);
        handshake();
        check("b2b gap ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check("b2b second taken", 32'(bus.req_ready), 32'd0);
        n = 1;
        wait_valid(n);
        check("b2b second latency", 32'(n), 32'd3);
        check("b2b src_op", 32'(bus.src_op), 32'h0002);
        check("b2b dst_op", 32'(bus.dst_op), 32'h1234);
        bus.req_valid = 1'b0;
        handshake();

        // Reset in the middle of FETCH_S
        present(1'b0, 3'd2, 3'd1);
        @(negedge clk);                  // cycle 2: FETCH_S
        #1 rst = 1'b1;
        #1;
        check("rst op_valid", 32'(bus.op_valid), 32'd0);
        check("rst src_op", 32'(bus.src_op), 32'd0);
        check("rst dst_op", 32'(bus.dst_op), 32'd0);
        check("rst rf_en", 32'(bus.rf_en), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst req_ready", 32'(bus.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("rst stays idle", 32'(bus.op_valid), 32'd0);
        do_txn("post rst", 1'b0, 3'd7, 3'd0, 16'h7FFF, 16'h0001);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
